// File: rtl/inst_prefetch_queue_pkg.sv
// Shared types and constants for the instruction prefetch queue.
package inst_prefetch_queue_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StDrop = 2'd2
    } fetch_state_e;

    localparam logic [31:0] PcStep     = 32'd4;
    localparam int unsigned EntryWidth = 64;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/inst_prefetch_queue_sync_fifo.sv
// Synchronous FIFO with flush; read data is taken directly from the head entry.
module inst_prefetch_queue_sync_fifo #(
    parameter int unsigned Width = 64,
    parameter int unsigned Depth = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    input  logic [Width-1:0]       wdata_i,
    output logic [Width-1:0]       rdata_o,
    output logic [$clog2(Depth):0] count_o,
    output logic                   empty_o,
    output logic                   full_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = PtrW + 1;

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  rd_ptr_q, wr_ptr_q;
    logic [CntW-1:0]  count_q;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CntW'(Depth));
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Storage is reset so the head never reads X, even while empty.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(Depth); i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
        end
    end

endmodule

// File: rtl/inst_prefetch_queue.sv
// Sequential instruction prefetcher: one outstanding memory request, results buffered
// with their PCs in a FIFO, flushed and restarted on redirect.
module inst_prefetch_queue
    import inst_prefetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_data_i,
    output logic        inst_valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] inst_pc_o,
    input  logic        inst_ready_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i
);

    localparam int unsigned CntW = $clog2(DEPTH) + 1;

    fetch_state_e    state_q, state_d;
    logic [31:0]     fetch_pc_q, fetch_pc_d;
    logic [31:0]     addr_q, addr_d;
    logic [CntW-1:0] count, count_next;
    logic            fifo_empty, fifo_full;
    logic            push, pop, flush;
    fetch_entry_t    head;

    inst_prefetch_queue_sync_fifo #(
        .Width(EntryWidth),
        .Depth(DEPTH)
    ) u_fifo (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .push_i (push),
        .pop_i  (pop),
        .flush_i(flush),
        .wdata_i({fetch_pc_q, mem_data_i}),
        .rdata_o(head),
        .count_o(count),
        .empty_o(fifo_empty),
        .full_o (fifo_full)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            fetch_pc_q <= RESET_PC;
            addr_q     <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            addr_q     <= addr_d;
        end
    end

    // Occupancy after this edge decides whether a back-to-back request may be issued.
    assign count_next = count + CntW'(push) - CntW'(pop);

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        addr_d     = addr_q;
        if (redirect_i) begin
            fetch_pc_d = redirect_pc_i & ~32'd3;
        end
        case (state_q)
            StIdle: begin
                if (!redirect_i && start_i && !fifo_full) begin
                    state_d = StReq;
                    addr_d  = fetch_pc_q;
                end
            end
            StReq: begin
                if (redirect_i) begin
                    state_d = mem_ack_i ? StIdle : StDrop;
                end else if (mem_ack_i) begin
                    fetch_pc_d = fetch_pc_q + PcStep;
                    if (start_i && (count_next < CntW'(DEPTH))) begin
                        addr_d = fetch_pc_d;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            // The in-flight handshake must finish; its data is thrown away.
            StDrop: begin
                if (mem_ack_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        mem_req_o  = (state_q != StIdle);
        mem_addr_o = addr_q;
        flush      = redirect_i;
        push       = (state_q == StReq) && mem_ack_i && !redirect_i;
        pop        = !fifo_empty && inst_ready_i && !redirect_i;
    end

    assign inst_valid_o = !fifo_empty;
    assign inst_o       = head.inst;
    assign inst_pc_o    = head.pc;

endmodule

// File: doc/inst_prefetch_queue.md
Name: inst_prefetch_queue

Overview:
- Fetch-side stage that sits upstream of the instruction decode path of the single-cycle CPU.
- Issues sequential word fetches to a multi-cycle instruction memory over a req/ack handshake.
- Buffers returned instructions with their PCs in a small FIFO and presents them to the CPU with a valid/ready interface.
- Flushes and restarts fetch at a new PC on a branch/jump redirect.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- start_i  in  1  fetch enable; when low, no new requests are issued.
- mem_req_o  out  1  fetch request to instruction memory.
- mem_addr_o  out  32  fetch word address; bits [1:0] are always 0.
- mem_ack_i  in  1  memory completion, sampled at the clock edge while mem_req_o=1.
- mem_data_i  in  32  instruction word, valid when mem_ack_i=1.
- inst_valid_o  out  1  FIFO head holds an instruction.
- inst_o  out  32  head instruction.
- inst_pc_o  out  32  PC of head instruction.
- inst_ready_i  in  1  CPU consumes the head this cycle when inst_valid_o=1.
- redirect_i  in  1  branch/jump taken; flush and refetch.
- redirect_pc_i  in  32  new fetch PC; bits [1:0] are ignored and forced to 0.

Behaviour:
- Reset (asynchronous): mem_req_o=0, mem_addr_o=RESET_PC, inst_valid_o=0, inst_o=0, inst_pc_o=0, FIFO empty, fetch_pc=RESET_PC, FSM=IDLE.
- FSM states and transitions:
  - IDLE: if start_i=1, redirect_i=0 and (count + 0) < DEPTH, go to REQ with mem_req_o=1 and mem_addr_o=fetch_pc.
  - REQ: mem_req_o and mem_addr_o stay stable until ack.
    - On ack: push {fetch_pc, mem_data_i}, set fetch_pc+=4 (wraps modulo 2^32).
    - After the ack, go to REQ again if start_i=1 and count_after_push < DEPTH; otherwise go to IDLE. Back-to-back requests are therefore possible.
  - DROP: entered from REQ when redirect_i=1 without an ack in the same cycle.
    - mem_req_o and the old address are held until ack (the handshake is never abandoned).
    - The returned data is discarded, then go to IDLE.
    - A further redirect while in DROP only updates fetch_pc.
- At most one request is outstanding. Issue is allowed only if count + outstanding < DEPTH, so a push never overflows.
- Latency: ack sampled at edge N gives inst_valid_o=1 from edge N (visible in cycle N+1). With an empty FIFO, start of fetch to first valid takes a minimum of 2 cycles.
- Pop occurs when inst_valid_o=1 and inst_ready_i=1. Push and pop in the same cycle leave count unchanged.
- Redirect takes priority over everything in the same cycle:
  - FIFO is flushed (count=0, inst_valid_o=0 next cycle) and any pop is ignored.
  - fetch_pc=redirect_pc_i&~3.
  - An ack in the same cycle is discarded and the FSM goes to IDLE.
  - If in REQ without ack, go to DROP.
- start_i low: the current outstanding request completes normally and the FIFO keeps draining.
- Empty with inst_ready_i=1: no effect. Full: no requests are issued, mem_req_o=0 in IDLE.
- Pointers wrap modulo DEPTH. count ranges 0..DEPTH.
- inst_o and inst_pc_o are driven from the FIFO head. Their values while inst_valid_o=0 are don't-care but must not be X after reset.

Decomposition:
- Shared package holds:
  - FSM state encoding (IDLE, REQ, DROP), 2 bits.
  - PC_STEP=4.
  - Entry width constant 64 for {pc, inst}.
- Sub-module: sync_fifo (width 64, DEPTH entries, push/pop/flush, count, empty/full), instantiated once.
- The FSM and fetch_pc live in the top.

Test Plan:
- Reset, start_i=1, memory acks 1 cycle after each req, inst_ready_i=1 -> PCs 0x0, 0x4, 0x8, ... delivered in order with matching data, no gaps after steady state.
- inst_ready_i=0, acks immediate -> exactly DEPTH=4 entries fetched (0x0..0xC), mem_req_o stays 0 while full. Raise ready for 1 cycle -> one pop, one new request for 0x10.
- Redirect to 0x103 while a request for 0x8 is outstanding (ack 3 cycles later) -> FSM goes to DROP, mem_addr_o stays 0x8 until ack, 0x8 data is never presented, next request is addr 0x100, and the first valid instruction has inst_pc_o=0x100.
- Redirect in the same cycle as ack and pop with the FIFO holding 2 entries -> all data discarded, inst_valid_o=0 next cycle, next request addr=redirect_pc.
- start_i dropped mid-request -> the outstanding request completes and is pushed, no further mem_req_o. Re-raise -> fetch resumes at the next sequential PC.
- rst_i asserted mid-REQ with no clock edge -> mem_req_o=0 and inst_valid_o=0 immediately. After release the first request is at RESET_PC.
